vend_controller: RTL and testbench

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_pkg.sv | 31 +++
 rtl/vend_change_gen.sv | 28 ++
 rtl/vend_controller.sv | 160 ++++++++++++++++
 tb/tb_vend_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: coin codes, FSM states,
// denominations and the coin-code-to-value helper.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_1    = 2'b01,
    COIN_5    = 2'b10,
    COIN_10   = 2'b11
  } coin_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam int DENOM_1  = 1;
  localparam int DENOM_5  = 5;
  localparam int DENOM_10 = 10;

  function automatic int coin_value(input logic [1:0] code);
    case (code)
      COIN_1:  return DENOM_1;
      COIN_5:  return DENOM_5;
      COIN_10: return DENOM_10;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Combinational change selector: picks the largest coin not exceeding the
// remaining credit and reports the credit left after paying it out.
module vend_change_gen
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] remaining,
  output logic [1:0]          code,
  output logic [CREDIT_W-1:0] remaining_next
);

  always_comb begin
    code           = COIN_NONE;
    remaining_next = remaining;
    if (remaining >= CREDIT_W'(DENOM_10)) begin
      code           = COIN_10;
      remaining_next = remaining - CREDIT_W'(DENOM_10);
    end else if (remaining >= CREDIT_W'(DENOM_5)) begin
      code           = COIN_5;
      remaining_next = remaining - CREDIT_W'(DENOM_5);
    end else if (remaining >= CREDIT_W'(DENOM_1)) begin
      code           = COIN_1;
      remaining_next = remaining - CREDIT_W'(DENOM_1);
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Vending machine controller: coin credit, edge-triggered product keys, change return.
// Per-item stock counters are built only when VEND_STOCK_EN is defined.
module vend_controller
  import vend_pkg::*;
#(
  parameter int                            NUM_ITEMS  = 4,
  parameter int                            CREDIT_W   = 8,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {8'd12, 8'd7, 8'd5, 8'd3},
  parameter int                            MAX_CREDIT = 50,
  parameter int                            STOCK_INIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           coin,
  input  logic [NUM_ITEMS-1:0] keys,
  input  logic                 cancel,
  input  logic                 restock,
  output logic [NUM_ITEMS-1:0] sell,
  output logic [1:0]           change,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 busy,
  output logic                 coin_reject,
  output logic [NUM_ITEMS-1:0] sold_out
);

  state_t                state_reg, state_next;
  logic [CREDIT_W-1:0]   credit_reg, credit_next;
  logic [NUM_ITEMS-1:0]  sell_reg, sell_next;
  logic [NUM_ITEMS-1:0]  keys_reg;
  logic                  coin_reject_reg, coin_reject_next;

  logic [NUM_ITEMS-1:0]  rise;
  logic [CREDIT_W-1:0]   price_arr [NUM_ITEMS];
  logic [CREDIT_W-1:0]   price_sel;
  logic                  sel_sold;
  logic [CREDIT_W:0]     coin_sum;
  logic                  in_change, coin_over, coin_ok, cancel_eff, sale;
  logic [1:0]            gen_code;
  logic [CREDIT_W-1:0]   gen_remaining;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ITEMS; gi++) begin : g_price
      assign price_arr[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];
    end
  endgenerate

  vend_change_gen #(.CREDIT_W(CREDIT_W)) u_change_gen (
    .remaining      (credit_reg),
    .code           (gen_code),
    .remaining_next (gen_remaining)
  );

  assign rise = keys & ~keys_reg;

  always_comb begin
    price_sel = '0;
    sel_sold  = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (rise[i]) begin
        price_sel = price_arr[i];
        sel_sold  = sold_out[i];
      end
    end
  end

  // Purchase decision uses pre-coin credit; a coin in the same cycle is added on top.
  always_comb begin
    state_next       = state_reg;
    credit_next      = credit_reg;
    sell_next        = '0;
    in_change        = (state_reg == CHANGE);
    coin_sum         = {1'b0, credit_reg} + (CREDIT_W+1)'(coin_value(coin));
    coin_over        = coin_sum > (CREDIT_W+1)'(MAX_CREDIT);
    coin_ok          = (coin != COIN_NONE) && !in_change && !coin_over;
    coin_reject_next = (coin != COIN_NONE) && (in_change || coin_over);
    cancel_eff       = cancel && !in_change && (credit_reg != '0);
    sale             = !in_change && !cancel_eff && $onehot(rise) &&
                       (credit_reg >= price_sel) && !sel_sold;

    if (in_change) begin
      credit_next = gen_remaining;
      if (gen_remaining == '0)
        state_next = IDLE;
    end else begin
      credit_next = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_reg;
      if (sale) begin
        credit_next = credit_next - price_sel;
        sell_next   = rise;
      end
      if (cancel_eff || (sale && credit_next != '0))
        state_next = CHANGE;
      else if (credit_next != '0)
        state_next = CREDIT;
      else
        state_next = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      credit_reg      <= '0;
      sell_reg        <= '0;
      keys_reg        <= '0;
      coin_reject_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      credit_reg      <= credit_next;
      sell_reg        <= sell_next;
      keys_reg        <= keys;
      coin_reject_reg <= coin_reject_next;
    end
  end

`ifdef VEND_STOCK_EN
  localparam int STOCK_W = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;

  logic restock_pend_reg;
  logic restock_req, restock_apply;

  // A restock coinciding with a sale is held over and applied on the first sale-free cycle.
  assign restock_req   = restock | restock_pend_reg;
  assign restock_apply = restock_req & ~(|sell_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      restock_pend_reg <= 1'b0;
    else
      restock_pend_reg <= restock_req & (|sell_next);
  end

  generate
    for (gi = 0; gi < NUM_ITEMS; gi++) begin : g_stock
      logic [STOCK_W-1:0] stock_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          stock_reg <= STOCK_W'(STOCK_INIT);
        else if (sell_next[gi])
          stock_reg <= stock_reg - 1'b1;
        else if (restock_apply)
          stock_reg <= STOCK_W'(STOCK_INIT);
      end
      assign sold_out[gi] = (stock_reg == '0);
    end
  endgenerate
`else
  localparam int UNUSED_STOCK_INIT = STOCK_INIT;
  logic unused_restock;
  assign unused_restock = restock;
  assign sold_out       = '0;
`endif

  assign sell        = sell_reg;
  assign credit      = credit_reg;
  assign coin_reject = coin_reject_reg;
  assign busy        = (state_reg == CHANGE);
  assign change      = busy ? gen_code : COIN_NONE;

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: stimulus queues expected output events,
// a negedge monitor pops and compares whenever sell/change/coin_reject is active.
module tb_vend_controller;

  logic       clk;
  logic       rst;
  logic [1:0] coin;
  logic [3:0] keys;
  logic       cancel;
  logic       restock;
  logic [3:0] sell;
  logic [1:0] change;
  logic [7:0] credit;
  logic       busy;
  logic       coin_reject;
  logic [3:0] sold_out;

  vend_controller dut (
    .clk         (clk),
    .rst         (rst),
    .coin        (coin),
    .keys        (keys),
    .cancel      (cancel),
    .restock     (restock),
    .sell        (sell),
    .change      (change),
    .credit      (credit),
    .busy        (busy),
    .coin_reject (coin_reject),
    .sold_out    (sold_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sell;
    logic [1:0] chg;
    logic       rej;
    logic [7:0] cr;
  } ev_t;

  ev_t exp_q[$];
  ev_t got_ev;
  ev_t exp_ev;
  int  vectors = 0;
  int  errors  = 0;

  task automatic push(input logic [3:0] s, input logic [1:0] c, input logic r, input logic [7:0] cr);
    ev_t e;
    e.sell = s; e.chg = c; e.rej = r; e.cr = cr;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end else
      $display("ok   %s = %0h", name, act);
  endtask

  task automatic step(input logic [1:0] c, input logic [3:0] k, input logic cn, input logic rs);
    coin = c; keys = k; cancel = cn; restock = rs;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && (sell != 4'd0 || change != 2'd0 || coin_reject)) begin
      got_ev = {sell, change, coin_reject, credit};
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got sell=%b change=%b rej=%b credit=%0d, expected no event",
                 sell, change, coin_reject, credit);
      end else begin
        exp_ev = exp_q.pop_front();
        if (got_ev !== exp_ev) begin
          errors++;
          $display("FAIL event: got sell=%b change=%b rej=%b credit=%0d, expected sell=%b change=%b rej=%b credit=%0d",
                   sell, change, coin_reject, credit, exp_ev.sell, exp_ev.chg, exp_ev.rej, exp_ev.cr);
        end else
          $display("ev   sell=%b change=%b rej=%b credit=%0d", sell, change, coin_reject, credit);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; coin = 2'b00; keys = 4'b0; cancel = 1'b0; restock = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_credit", credit, 0);
    chk("reset_sell", sell, 0);
    chk("reset_change", change, 0);
    chk("reset_busy", busy, 0);
    chk("reset_reject", coin_reject, 0);
    chk("reset_sold_out", sold_out, 0);
    rst = 1'b0;
    step(2'b00, 4'b0, 0, 0);

    // Coin 10, buy item 1 (price 5), one 5-coin of change
    step(2'b11, 4'b0000, 0, 0);
    chk("a_credit_after_coin", credit, 10);
    push(4'b0010, 2'b10, 0, 5);
    step(2'b00, 4'b0010, 0, 0);
    step(2'b00, 4'b0010, 0, 0);
    chk("a_credit_end", credit, 0);
    chk("a_busy_end", busy, 0);
    step(2'b00, 4'b0000, 0, 0);

    // Coins 5+1, item 3 too expensive, then cancel
    step(2'b10, 4'b0000, 0, 0);
    step(2'b01, 4'b0000, 0, 0);
    step(2'b00, 4'b1000, 0, 0);
    chk("b_credit_no_sale", credit, 6);
    push(4'b0000, 2'b10, 0, 6);
    step(2'b00, 4'b0000, 1, 0);
    push(4'b0000, 2'b01, 0, 1);
    step(2'b00, 4'b0000, 0, 0);
    step(2'b00, 4'b0000, 0, 0);
    chk("b_credit_end", credit, 0);
    chk("b_busy_end", busy, 0);

    // Key 0 held five cycles: exactly one sale
    step(2'b11, 4'b0000, 0, 0);
    push(4'b0001, 2'b10, 0, 7);
    step(2'b00, 4'b0001, 0, 0);
    push(4'b0000, 2'b01, 0, 2);
    step(2'b00, 4'b0001, 0, 0);
    push(4'b0000, 2'b01, 0, 1);
    step(2'b00, 4'b0001, 0, 0);
    step(2'b00, 4'b0001, 0, 0);
    step(2'b00, 4'b0001, 0, 0);
    step(2'b00, 4'b0000, 0, 0);
    chk("c_credit_end", credit, 0);

    // Credit ceiling and coin during CHANGE
    repeat (4) step(2'b11, 4'b0000, 0, 0);
    step(2'b10, 4'b0000, 0, 0);
    chk("d_credit_45", credit, 45);
    push(4'b0000, 2'b00, 1, 45);
    step(2'b11, 4'b0000, 0, 0);
    step(2'b00, 4'b0000, 0, 0);
    chk("d_credit_held", credit, 45);
    push(4'b0000, 2'b11, 0, 45);
    step(2'b00, 4'b0000, 1, 0);
    push(4'b0000, 2'b11, 1, 35);
    step(2'b01, 4'b0000, 0, 0);
    push(4'b0000, 2'b11, 0, 25);
    step(2'b00, 4'b0000, 0, 0);
    push(4'b0000, 2'b11, 0, 15);
    step(2'b00, 4'b0000, 0, 0);
    push(4'b0000, 2'b10, 0, 5);
    step(2'b00, 4'b0000, 0, 0);
    step(2'b00, 4'b0000, 0, 0);
    chk("d_credit_end", credit, 0);

    // Coin and sale in the same cycle: 10 + 5 - 3 = 12
    step(2'b11, 4'b0000, 0, 0);
    push(4'b0001, 2'b11, 0, 12);
    step(2'b10, 4'b0001, 0, 0);
    push(4'b0000, 2'b01, 0, 2);
    step(2'b00, 4'b0000, 0, 0);
    push(4'b0000, 2'b01, 0, 1);
    step(2'b00, 4'b0000, 0, 0);
    step(2'b00, 4'b0000, 0, 0);
    chk("g_credit_end", credit, 0);

    // Two keys rising together are ignored
    step(2'b11, 4'b0000, 0, 0);
    step(2'b00, 4'b0011, 0, 0);
    chk("h_credit_multi_key", credit, 10);
    push(4'b0000, 2'b11, 0, 10);
    step(2'b00, 4'b0011, 1, 0);
    step(2'b00, 4'b0000, 0, 0);
    chk("h_credit_end", credit, 0);

    // Three purchases of item 2 (price 7)
    for (int n = 0; n < 3; n++) begin
      step(2'b11, 4'b0000, 0, 0);
      push(4'b0100, 2'b01, 0, 3);
      step(2'b00, 4'b0100, 0, 0);
      push(4'b0000, 2'b01, 0, 2);
      step(2'b00, 4'b0000, 0, 0);
      push(4'b0000, 2'b01, 0, 1);
      step(2'b00, 4'b0000, 0, 0);
      step(2'b00, 4'b0000, 0, 0);
    end
`ifdef VEND_STOCK_EN
    chk("e_sold_out_after_3", sold_out, 4'b0100);
    step(2'b11, 4'b0000, 0, 0);
    step(2'b00, 4'b0100, 0, 0);
    chk("e_no_sale_sold_out", credit, 10);
    push(4'b0000, 2'b11, 0, 10);
    step(2'b00, 4'b0000, 1, 0);
    step(2'b00, 4'b0000, 0, 0);
`else
    chk("e_sold_out_tied", sold_out, 4'b0000);
    step(2'b11, 4'b0000, 0, 0);
    push(4'b0100, 2'b01, 0, 3);
    step(2'b00, 4'b0100, 0, 0);
    push(4'b0000, 2'b01, 0, 2);
    step(2'b00, 4'b0000, 0, 0);
    push(4'b0000, 2'b01, 0, 1);
    step(2'b00, 4'b0000, 0, 0);
    step(2'b00, 4'b0000, 0, 0);
`endif
    chk("e_credit_end", credit, 0);
    step(2'b00, 4'b0000, 0, 1);
    step(2'b00, 4'b0000, 0, 0);
    chk("e_sold_out_restocked", sold_out, 4'b0000);

    // Reset asserted mid-CHANGE
    step(2'b11, 4'b0000, 0, 0);
    step(2'b11, 4'b0000, 0, 0);
    push(4'b0000, 2'b11, 0, 20);
    step(2'b00, 4'b0000, 1, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("f_rst_change", change, 0);
    chk("f_rst_credit", credit, 0);
    chk("f_rst_busy", busy, 0);
    chk("f_rst_sell", sell, 0);
    chk("f_rst_reject", coin_reject, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step(2'b00, 4'b0000, 0, 0);
    chk("f_credit_after_rst", credit, 0);
    chk("f_change_after_rst", change, 0);

    repeat (2) step(2'b00, 4'b0000, 0, 0);
    chk("pending_events", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
